// File: rtl/uart_wb_sequencer.sv
// uart_wb_sequencer: Wishbone master that configures a 16550 UART and moves bytes between streams and THR/RBR
// Ports: clk/rst_n (async active-low); wb_* classic Wishbone master to uart_top;
// tx_data/tx_valid/tx_ready transmit stream in; rx_data/rx_valid/rx_ready receive stream out;
// cfg_done sticky after configuration; err sticky on ack timeout.
module uart_wb_sequencer #(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter logic [7:0]  FCR_VAL     = 8'h07,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       err
);
    typedef enum logic [3:0] {CFG0, CFG1, CFG2, CFG3, CFG4, CFG5, IDLE, POLL, RD_RBR, WR_THR, ERR} state_t;
    state_t state;
    logic [7:0] tmo_cnt;
    logic [2:0] acc_adr;
    logic [7:0] acc_dat;
    logic       acc_we;
    // IDLE issues the LSR poll directly, so it shares the POLL access
    always_comb begin
        acc_adr = 3'd5;
        acc_dat = 8'h00;
        acc_we  = 1'b1;
        unique case (state)
            CFG0:       begin acc_adr = 3'd3; acc_dat = 8'h80 | LCR_VAL; end
            CFG1:       begin acc_adr = 3'd0; acc_dat = DIVISOR[7:0]; end
            CFG2:       begin acc_adr = 3'd1; acc_dat = DIVISOR[15:8]; end
            CFG3:       begin acc_adr = 3'd3; acc_dat = LCR_VAL; end
            CFG4:       begin acc_adr = 3'd2; acc_dat = FCR_VAL; end
            CFG5:       acc_adr = 3'd1;
            RD_RBR:     begin acc_adr = 3'd0; acc_we = 1'b0; end
            WR_THR:     begin acc_adr = 3'd0; acc_dat = tx_data; end
            default:    acc_we = 1'b0;
        endcase
    end
    assign wb_sel_o = {4{wb_cyc_o}};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CFG0;
            tmo_cnt  <= 8'd0;
            wb_adr_o <= 3'd0;
            wb_dat_o <= 8'd0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            tx_ready <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            cfg_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (wb_cyc_o) begin
                // ack is tested before the timeout so a late ack still completes the access
                if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    unique case (state)
                        CFG5:    begin cfg_done <= 1'b1; state <= IDLE; end
                        POLL:    state <= (wb_dat_i[0] && !rx_valid) ? RD_RBR :
                                          (wb_dat_i[5] && tx_valid) ? WR_THR : IDLE;
                        RD_RBR:  begin rx_data <= wb_dat_i; rx_valid <= 1'b1; state <= IDLE; end
                        WR_THR:  begin tx_ready <= 1'b1; state <= IDLE; end
                        default: state <= state_t'(state + 4'd1);
                    endcase
                end else if (tmo_cnt == ACK_TIMEOUT - 8'd1) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    err      <= 1'b1;
                    state    <= ERR;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end else if (state != ERR && (state != IDLE || !rx_valid || tx_valid)) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= acc_we;
                wb_adr_o <= acc_adr;
                wb_dat_o <= acc_dat;
                tmo_cnt  <= 8'd0;
                if (state == IDLE)
                    state <= POLL;
            end
        end
    end
endmodule
